// File: rtl/vthernet_pkg.sv
// rtl/vthernet_pkg.sv - shared constants and types for the vthernet GMII receive path
package vthernet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int DEFAULT_MIN_LEN = 64;
    localparam int DEFAULT_MAX_LEN = 1518;

endpackage

// File: rtl/vthernet_crc32_byte.sv
// rtl/vthernet_crc32_byte.sv - combinational byte-wide reflected CRC-32 step, LSB first
module vthernet_crc32_byte
    import vthernet_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (CRC32_POLY & {32{c[0] ^ data[i]}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/vthernet_rx_frame_checker.sv
// rtl/vthernet_rx_frame_checker.sv - GMII RX frame checker with FCS strip; VTHERNET_RX_STATS_EN adds good/bad counters
module vthernet_rx_frame_checker
    import vthernet_pkg::*;
#(
    parameter int MIN_LEN = DEFAULT_MIN_LEN,
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX_DV,
    input  logic [7:0]  RXD,
    input  logic        RX_ER,
    output logic        rx_data_valid,
    output logic [7:0]  rx_data,
    output logic        rx_data_first,
    output logic        rx_frame_done,
    output logic        rx_frame_ok,
    output logic        rx_fcs_err,
    output logic        rx_len_err,
    output logic        rx_phy_err,
    output logic [10:0] rx_frame_len,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_bad_cnt
);

    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

    rx_state_t   state;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [10:0] len;
    logic        phy_err;
    logic [7:0]  dly [0:3];
    logic [2:0]  dly_cnt;
    logic        awaiting_first;
    logic        pend_valid;
    logic        pend_first;
    logic [7:0]  pend_data;

    logic        frame_end;
    logic        fcs_err_w;
    logic        len_err_w;
    logic        frame_ok_w;

    vthernet_crc32_byte u_crc (
        .crc_in  (crc),
        .data    (RXD),
        .crc_out (crc_next)
    );

    assign frame_end  = (state == ST_DATA) && !RX_DV;
    assign fcs_err_w  = (crc != CRC32_RESIDUE);
    assign len_err_w  = (len < MIN_LEN_L) || (len > MAX_LEN_L);
    assign frame_ok_w = !(fcs_err_w || len_err_w || phy_err);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            crc            <= '0;
            len            <= '0;
            phy_err        <= 1'b0;
            dly_cnt        <= '0;
            awaiting_first <= 1'b0;
            pend_valid     <= 1'b0;
            pend_first     <= 1'b0;
            pend_data      <= '0;
            for (int i = 0; i < 4; i++) dly[i] <= '0;
            rx_data_valid  <= 1'b0;
            rx_data        <= '0;
            rx_data_first  <= 1'b0;
            rx_frame_done  <= 1'b0;
            rx_frame_ok    <= 1'b0;
            rx_fcs_err     <= 1'b0;
            rx_len_err     <= 1'b0;
            rx_phy_err     <= 1'b0;
            rx_frame_len   <= '0;
        end else begin
            rx_frame_done <= 1'b0;
            pend_valid    <= 1'b0;
            // Evicted byte spends one cycle in the pend stage, giving a 5-cycle sample-to-emit latency
            rx_data_valid <= pend_valid;
            rx_data_first <= pend_valid & pend_first;
            if (pend_valid) rx_data <= pend_data;

            case (state)
                ST_IDLE: begin
                    if (RX_DV) state <= (RXD == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
                ST_PREAMBLE: begin
                    if (!RX_DV) begin
                        state <= ST_IDLE;
                    end else if (RXD == SFD_BYTE) begin
                        state          <= ST_DATA;
                        crc            <= CRC32_INIT;
                        len            <= '0;
                        phy_err        <= 1'b0;
                        dly_cnt        <= '0;
                        awaiting_first <= 1'b1;
                    end else if (RXD != PREAMBLE_BYTE) begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (frame_end) begin
                        state         <= ST_IDLE;
                        rx_frame_done <= 1'b1;
                        rx_frame_ok   <= frame_ok_w;
                        rx_fcs_err    <= fcs_err_w;
                        rx_len_err    <= len_err_w;
                        rx_phy_err    <= phy_err;
                        rx_frame_len  <= len;
                    end else begin
                        crc <= crc_next;
                        if (len != 11'h7FF) len <= len + 11'd1;
                        if (RX_ER) phy_err <= 1'b1;
                        dly[0] <= RXD;
                        dly[1] <= dly[0];
                        dly[2] <= dly[1];
                        dly[3] <= dly[2];
                        // Holding back four bytes means the FCS is never forwarded
                        if (dly_cnt == 3'd4) begin
                            pend_valid     <= 1'b1;
                            pend_data      <= dly[3];
                            pend_first     <= awaiting_first;
                            awaiting_first <= 1'b0;
                        end else begin
                            dly_cnt <= dly_cnt + 3'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (!RX_DV) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VTHERNET_RX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_good_cnt <= '0;
            rx_bad_cnt  <= '0;
        end else if (frame_end) begin
            if (frame_ok_w) begin
                if (rx_good_cnt != 16'hFFFF) rx_good_cnt <= rx_good_cnt + 16'd1;
            end else begin
                if (rx_bad_cnt != 16'hFFFF) rx_bad_cnt <= rx_bad_cnt + 16'd1;
            end
        end
    end
`else
    assign rx_good_cnt = '0;
    assign rx_bad_cnt  = '0;
`endif

endmodule

// File: doc/vthernet_rx_frame_checker.md
VTHERNET_RX_FRAME_CHECKER -- requirements
Module: vthernet_rx_frame_checker

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes, counted from after SFD and including FCS.
REQ-002 Parameter MAX_LEN, default 1518, maximum legal frame length in bytes, counted the same way.
REQ-003 clk  input  1  single clock; GMII RX inputs are synchronous to it.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 RX_DV  input  1  GMII receive data valid.
REQ-006 RXD  input  8  GMII receive data.
REQ-007 RX_ER  input  1  GMII receive error.
REQ-008 rx_data_valid  output  1  payload byte strobe to the downstream RX MAC.
REQ-009 rx_data  output  8  payload byte (DA through last pre-FCS byte).
REQ-010 rx_data_first  output  1  high with the first payload byte of a frame.
REQ-011 rx_frame_done  output  1  one-cycle frame status strobe.
REQ-012 rx_frame_ok, rx_fcs_err, rx_len_err, rx_phy_err  output  1 each  status flags, valid with rx_frame_done.
REQ-013 rx_frame_len  output  11  post-SFD byte count including FCS, valid with rx_frame_done.
REQ-014 rx_good_cnt, rx_bad_cnt  output  16 each  frame statistics counters (see Configuration).

Function
REQ-015 States SHALL be IDLE, PREAMBLE, DATA and DROP.
- IDLE: RX_DV=1 and RXD=0x55 -> PREAMBLE; RX_DV=1 with any other byte -> DROP.
REQ-016 PREAMBLE:
- RX_DV=1, RXD=0x55 -> stay.
- RX_DV=1, RXD=0xD5 -> DATA; CRC init 0xFFFFFFFF, len=0, flags clear.
- RX_DV=1, other byte -> DROP.
- RX_DV=0 -> IDLE.
- No status is issued on any of these exits.
REQ-017 DROP: no outputs; RX_DV=0 -> IDLE.
REQ-018 DATA, RX_DV=1: per byte, SHALL update CRC (reflected poly 0xEDB88320, LSB first), increment len (saturating at 2047), and push the byte into a 4-byte delay line.
REQ-019 Payload output: when the delay line is full and a new byte is pushed, the evicted byte SHALL appear on rx_data with rx_data_valid=1 on the next clock.
- Latency is 5 cycles from sampling byte k to emitting byte k.
- The final 4 bytes (FCS) are never emitted.
REQ-020 rx_data_first SHALL accompany only the first emitted byte of each frame.
REQ-021 RX_ER=1 while in DATA SHALL set phy_err sticky for the frame; reception continues.
REQ-022 DATA, RX_DV=0: the cycle after that sample, the block SHALL assert rx_frame_done for exactly 1 cycle and return to IDLE. Flags:
- rx_fcs_err = (CRC != 0xDEBB20E3)
- rx_len_err = (len < MIN_LEN or len > MAX_LEN)
- rx_phy_err = sticky flag
- rx_frame_ok = none of the three
REQ-023 Frames with fewer than 5 post-SFD bytes SHALL emit no payload and SHALL report rx_len_err=1 and rx_fcs_err per REQ-022.
REQ-024 Back-to-back frames: the block SHALL accept a new preamble on the first RX_DV=1 cycle after any RX_DV=0 cycle, including the rx_frame_done cycle.
REQ-025 Status outputs SHALL hold their last values between strobes; rx_data SHALL hold its value when rx_data_valid=0.

Reset
REQ-026 Asserting rst SHALL immediately force:
- state=IDLE
- all outputs, counters, CRC and delay line to 0 (CRC loads 0xFFFFFFFF at the next SFD)
REQ-027 A frame interrupted by reset SHALL produce no status strobe and no further payload; reception restarts at the next preamble after deassertion.

Configuration
REQ-028 Macro VTHERNET_RX_STATS_EN defined:
- on each rx_frame_done, rx_good_cnt increments if rx_frame_ok, else rx_bad_cnt increments
- both counters saturate at 0xFFFF
REQ-029 VTHERNET_RX_STATS_EN undefined: the counters SHALL NOT be implemented and rx_good_cnt/rx_bad_cnt SHALL be tied to 0.

Structure
REQ-030 Package vthernet_pkg SHALL hold:
- state enum
- CRC polynomial, init and residue constants
- preamble/SFD byte constants
- default MIN_LEN/MAX_LEN
REQ-031 The byte-wide CRC-32 next-state function SHALL be a combinational sub-module vthernet_crc32_byte, reusable by the TX MAC.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 60 rx_data_valid pulses; rx_frame_done with ok=1, len=64, good_cnt=1.
- Same frame with one payload bit flipped -> fcs_err=1, ok=0, bad_cnt=1.
- 0xD5 followed by 1519 bytes with valid FCS -> len_err=1, len=1519; 1515 bytes emitted.
- RX_ER pulsed mid-payload on a valid 64-byte frame -> phy_err=1, ok=0, fcs_err=0.
- Preamble 0x55,0x55,0x5A then RX_DV held 10 cycles; a valid frame follows one idle cycle after the first frame's done -> no output for the first, ok=1 for the second.
- rst asserted at payload byte 20 -> outputs 0 immediately, no rx_frame_done; next valid frame ok=1.
